// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debounce slice: FSM encoding and
// the active-low button level names.
package btn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE_HI = 2'b00,
      ST_WAIT_LO = 2'b01,
      ST_IDLE_LO = 2'b10,
      ST_WAIT_HI = 2'b11
   } state_t;

   localparam logic RELEASED = 1'b1;
   localparam logic PRESSED  = 1'b0;

   // Width of a counter that must hold values 0 .. cycles-1.
   function automatic int cnt_width(input int cycles);
      return (cycles > 2) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce_sync_ff.sv
// Plain N-stage flop synchroniser for an asynchronous pad input; the chain
// resets to RESET_VAL so a released button reads as released straight away.
module sync_ff #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_chain <= {STAGES{RESET_VAL}};
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Debounces an active-low push-button: synchronise, then qualify each new
// level for DEBOUNCE_CYCLES+1 consecutive samples; count aborted attempts.
//
//   state      | meaning
//   IDLE_HI    | button accepted as released, watching for a press
//   WAIT_LO    | press seen, qualifying it with cnt
//   IDLE_LO    | button accepted as pressed, watching for a release
//   WAIT_HI    | release seen, qualifying it with cnt
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SYNC_STAGES     = 2,
   parameter int GLITCH_W        = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                btn_n,
   output logic                btn_db,
   output logic                btn_stable,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   import btn_pkg::*;

   localparam int                CNT_W      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

   logic                w_s;
   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_db;
   logic                r_stable;
   logic [GLITCH_W-1:0] r_glitch;

   sync_ff #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (RELEASED)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (btn_n),
      .o_q   (w_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE_HI;
         r_cnt    <= '0;
         r_db     <= RELEASED;
         r_stable <= 1'b1;
         r_glitch <= '0;
      end else begin
         case (r_state)
            ST_IDLE_HI: begin
               if (w_s == PRESSED) begin
                  r_state  <= ST_WAIT_LO;
                  r_cnt    <= '0;
                  r_stable <= 1'b0;
               end
            end
            ST_WAIT_LO: begin
               // A reversion wins even on the final count: the level is not taken.
               if (w_s == RELEASED) begin
                  r_state  <= ST_IDLE_HI;
                  r_stable <= 1'b1;
                  if (r_glitch != GLITCH_MAX) r_glitch <= r_glitch + 1'b1;
               end else if (r_cnt == CNT_LAST) begin
                  r_state  <= ST_IDLE_LO;
                  r_db     <= PRESSED;
                  r_stable <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_IDLE_LO: begin
               if (w_s == RELEASED) begin
                  r_state  <= ST_WAIT_HI;
                  r_cnt    <= '0;
                  r_stable <= 1'b0;
               end
            end
            ST_WAIT_HI: begin
               if (w_s == PRESSED) begin
                  r_state  <= ST_IDLE_LO;
                  r_stable <= 1'b1;
                  if (r_glitch != GLITCH_MAX) r_glitch <= r_glitch + 1'b1;
               end else if (r_cnt == CNT_LAST) begin
                  r_state  <= ST_IDLE_HI;
                  r_db     <= RELEASED;
                  r_stable <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state  <= ST_IDLE_HI;
               r_stable <= 1'b1;
            end
         endcase
      end
   end

   assign btn_db     = r_db;
   assign btn_stable = r_stable;
   assign glitch_cnt = r_glitch;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: stimulus pushes the model's expected
// outputs per clock, a monitor pops and compares after each rising edge.
module tb_btn_debounce;

   localparam int DEB  = 4;
   localparam int SYNC = 2;
   localparam int GW   = 8;
   localparam int GMAX = (1 << GW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          btn_n = 1'b1;
   logic          btn_db;
   logic          btn_stable;
   logic [GW-1:0] glitch_cnt;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic          db;
      logic          stable;
      logic [GW-1:0] glitch;
   } exp_t;

   exp_t q[$];

   // Reference model: a delay line for the synchroniser plus the length of
   // the current run of samples that disagree with the accepted level.
   logic m_pipe[SYNC];
   logic m_db;
   int   m_run;
   int   m_glitch;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEB),
      .SYNC_STAGES     (SYNC),
      .GLITCH_W        (GW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_n      (btn_n),
      .btn_db     (btn_db),
      .btn_stable (btn_stable),
      .glitch_cnt (glitch_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic step(input logic rst, input logic b);
      logic view;
      @(negedge clk);
      reset = rst;
      btn_n = b;
      if (rst) begin
         for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b1;
         m_db     = 1'b1;
         m_run    = 0;
         m_glitch = 0;
      end else begin
         view = m_pipe[SYNC-1];
         for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
         m_pipe[0] = b;
         if (view != m_db) begin
            m_run++;
            if (m_run == DEB + 1) begin
               m_db  = view;
               m_run = 0;
            end
         end else if (m_run > 0) begin
            m_run = 0;
            if (m_glitch < GMAX) m_glitch++;
         end
      end
      q.push_back({m_db, (m_run == 0), GW'(m_glitch)});
   endtask

   task automatic hold(input logic b, input int n);
      for (int i = 0; i < n; i++) step(1'b0, b);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("btn_db",     int'(btn_db),     int'(e.db));
         chk("btn_stable", int'(btn_stable), int'(e.stable));
         chk("glitch_cnt", int'(glitch_cnt), int'(e.glitch));
      end
   end

   initial begin
      int len;
      logic lvl;

      // reset held with the button pressed, then the press qualifies
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      hold(1'b0, 10);
      hold(1'b1, 10);

      // clean press and release
      step(1'b1, 1'b1);
      hold(1'b1, 3);
      hold(1'b0, 10);
      hold(1'b1, 10);

      // bounce on press
      hold(1'b0, 2);
      hold(1'b1, 1);
      hold(1'b0, 10);
      hold(1'b1, 10);

      // boundary: reversion on the final count aborts; one more sample accepts
      hold(1'b0, DEB);
      hold(1'b1, 8);
      hold(1'b0, DEB + 1);
      hold(1'b1, 10);

      // reset in the middle of a press qualification
      hold(1'b0, 4);
      step(1'b1, 1'b0);
      hold(1'b1, 6);

      // glitch counter saturation from both idle levels
      for (int i = 0; i < 300; i++) begin
         hold(1'b0, 1);
         hold(1'b1, 1);
      end
      hold(1'b1, 4);
      hold(1'b0, 10);
      for (int i = 0; i < 10; i++) begin
         hold(1'b1, 1);
         hold(1'b0, 1);
      end
      hold(1'b0, 4);
      @(posedge clk);
      #2;
      chk("glitch_saturated", int'(glitch_cnt), GMAX);

      // random bouncing with occasional reset
      step(1'b1, 1'b1);
      lvl = 1'b1;
      for (int i = 0; i < 600; i++) begin
         lvl = ~lvl;
         len = $urandom_range(1, 8);
         if ($urandom_range(0, 99) == 0) step(1'b1, lvl);
         hold(lvl, len);
      end

      repeat (3) @(posedge clk);
      #2;
      chk("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
